// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one unified memory between the RV32I core and the host port.
// Define MEM_ARB_PERF_EN to add saturating grant/conflict counters with a perf_clr input.
module mem_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_ack,
   output logic              host_rvalid,
   output logic [DATA_W-1:0] host_rdata,
`ifdef MEM_ARB_PERF_EN
   input  logic              perf_clr,
   output logic [31:0]       perf_cpu_grants,
   output logic [31:0]       perf_host_grants,
   output logic [31:0]       perf_conflicts,
`endif
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_ACC  = 1'b1;
   localparam logic ID_CPU  = 1'b0;
   localparam logic ID_HOST = 1'b1;

   logic              state;
   logic              last_grant;
   logic              lat_id;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;

   logic              any_req;
   logic              grant_host;
   logic              in_acc;

   // NOTE: every signal assigned in always_comb gets a default first, so no latch can be inferred.
   always_comb begin
      any_req    = cpu_req | host_req;
      grant_host = 1'b0;
      if (host_req && (!cpu_req || last_grant == ID_CPU))
         grant_host = 1'b1;
   end

   assign in_acc    = (state == ST_ACC);
   assign cpu_ack   = in_acc && (lat_id == ID_CPU);
   assign host_ack  = in_acc && (lat_id == ID_HOST);
   assign mem_addr  = in_acc ? lat_addr  : '0;
   assign mem_wdata = in_acc ? lat_wdata : '0;
   // Gated by reset so an access interrupted by reset never commits a write.
   assign mem_we    = in_acc & lat_we & ~reset;

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         last_grant  <= ID_HOST;
         lat_id      <= ID_CPU;
         lat_we      <= 1'b0;
         lat_addr    <= '0;
         lat_wdata   <= '0;
         cpu_rvalid  <= 1'b0;
         host_rvalid <= 1'b0;
         cpu_rdata   <= '0;
         host_rdata  <= '0;
      end else begin
         cpu_rvalid  <= 1'b0;
         host_rvalid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  lat_id    <= grant_host;
                  lat_we    <= grant_host ? host_we    : cpu_we;
                  lat_addr  <= grant_host ? host_addr  : cpu_addr;
                  lat_wdata <= grant_host ? host_wdata : cpu_wdata;
                  state     <= ST_ACC;
               end
            end
            default: begin
               state      <= ST_IDLE;
               last_grant <= lat_id;
               if (!lat_we) begin
                  if (lat_id == ID_CPU) begin
                     cpu_rdata  <= mem_rdata;
                     cpu_rvalid <= 1'b1;
                  end else begin
                     host_rdata  <= mem_rdata;
                     host_rvalid <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

`ifdef MEM_ARB_PERF_EN
   logic idle_edge;
   assign idle_edge = (state == ST_IDLE);

   always_ff @(posedge clk) begin
      if (reset || perf_clr) begin
         perf_cpu_grants  <= '0;
         perf_host_grants <= '0;
         perf_conflicts   <= '0;
      end else if (idle_edge && any_req) begin
         if (grant_host) begin
            if (perf_host_grants != '1) perf_host_grants <= perf_host_grants + 32'd1;
         end else begin
            if (perf_cpu_grants != '1) perf_cpu_grants <= perf_cpu_grants + 32'd1;
         end
         if (cpu_req && host_req && perf_conflicts != '1)
            perf_conflicts <= perf_conflicts + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus contention, held-request, reset and perf sequences.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we, host_req, host_we;
   logic [31:0] cpu_addr, cpu_wdata, host_addr, host_wdata;
   logic        cpu_ack, cpu_rvalid, host_ack, host_rvalid;
   logic [31:0] cpu_rdata, host_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_we;
`ifdef MEM_ARB_PERF_EN
   logic        perf_clr;
   logic [31:0] perf_cpu_grants, perf_host_grants, perf_conflicts;
`endif

   logic [31:0] mem [0:63];
   int          passed = 0;
   int          total  = 0;

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr[7:2]];
   always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

   mem_port_arbiter dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_ack(host_ack), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
`ifdef MEM_ARB_PERF_EN
      .perf_clr(perf_clr), .perf_cpu_grants(perf_cpu_grants),
      .perf_host_grants(perf_host_grants), .perf_conflicts(perf_conflicts),
`endif
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
   );

   typedef struct {
      logic        cr, cw;
      logic [31:0] ca, cd;
      logic        hr, hw;
      logic [31:0] ha, hd;
      logic        e_cack, e_crv;
      logic [31:0] e_crd;
      logic        e_hack, e_hrv;
      logic [31:0] e_hrd;
      logic        e_mwe;
      logic [31:0] e_maddr, e_mwd;
   } vec_t;

   vec_t vecs [9];

   localparam logic [31:0] R = 32'h00A00093;
   localparam logic [31:0] D = 32'hDEADBEEF;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, required %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int rv_idx [2];
      int n_rv;

      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[4]  = R;
      mem[16] = 32'h11111111;

      reset = 1'b1;
      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
`ifdef MEM_ARB_PERF_EN
      perf_clr = 1'b0;
`endif

      //            cr cw ca     cd  hr hw ha     hd   cack crv crd hack hrv hrd mwe maddr  mwd
      vecs[0] = '{1, 0, 32'h10, 0, 0, 0, 0,     0,   0, 0, 0, 0, 0, 0, 0, 0,     0};
      vecs[1] = '{0, 0, 0,      0, 0, 0, 0,     0,   1, 0, 0, 0, 0, 0, 0, 32'h10, 0};
      vecs[2] = '{0, 0, 0,      0, 0, 0, 0,     0,   0, 1, R, 0, 0, 0, 0, 0,     0};
      vecs[3] = '{0, 0, 0,      0, 1, 1, 32'h20, D,  0, 0, R, 0, 0, 0, 0, 0,     0};
      vecs[4] = '{0, 0, 0,      0, 0, 0, 0,     0,   0, 0, R, 1, 0, 0, 1, 32'h20, D};
      vecs[5] = '{1, 0, 32'h20, 0, 0, 0, 0,     0,   0, 0, R, 0, 0, 0, 0, 0,     0};
      vecs[6] = '{0, 0, 0,      0, 0, 0, 0,     0,   1, 0, R, 0, 0, 0, 0, 32'h20, 0};
      vecs[7] = '{0, 0, 0,      0, 0, 0, 0,     0,   0, 1, D, 0, 0, 0, 0, 0,     0};
      vecs[8] = '{0, 0, 0,      0, 0, 0, 0,     0,   0, 0, D, 0, 0, 0, 0, 0,     0};

      tick(); tick();
      reset = 1'b0;

      // Table: CPU read of 0x10, host write of 0x20, CPU read-back of 0x20.
      for (int i = 0; i < 9; i++) begin
         cpu_req = vecs[i].cr;  cpu_we = vecs[i].cw;  cpu_addr = vecs[i].ca;  cpu_wdata = vecs[i].cd;
         host_req = vecs[i].hr; host_we = vecs[i].hw; host_addr = vecs[i].ha; host_wdata = vecs[i].hd;
         @(negedge clk);
         check($sformatf("v%0d cpu_ack", i),     32'(cpu_ack),     32'(vecs[i].e_cack));
         check($sformatf("v%0d cpu_rvalid", i),  32'(cpu_rvalid),  32'(vecs[i].e_crv));
         check($sformatf("v%0d cpu_rdata", i),   cpu_rdata,        vecs[i].e_crd);
         check($sformatf("v%0d host_ack", i),    32'(host_ack),    32'(vecs[i].e_hack));
         check($sformatf("v%0d host_rvalid", i), 32'(host_rvalid), 32'(vecs[i].e_hrv));
         check($sformatf("v%0d host_rdata", i),  host_rdata,       vecs[i].e_hrd);
         check($sformatf("v%0d mem_we", i),      32'(mem_we),      32'(vecs[i].e_mwe));
         check($sformatf("v%0d mem_addr", i),    mem_addr,         vecs[i].e_maddr);
         check($sformatf("v%0d mem_wdata", i),   mem_wdata,        vecs[i].e_mwd);
         tick();
      end
      check("mem word 0x20", mem[8], D);

      // Continuous contention from reset: CPU first, then alternating, one ack per port per 4 cycles.
      reset = 1'b1;
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
      host_req = 1; host_we = 0; host_addr = 32'h20;
      tick();
      reset = 1'b0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         check($sformatf("rr c%0d cpu_ack", c),     32'(cpu_ack),     32'(c % 4 == 1));
         check($sformatf("rr c%0d host_ack", c),    32'(host_ack),    32'(c % 4 == 3));
         check($sformatf("rr c%0d cpu_rvalid", c),  32'(cpu_rvalid),  32'(c % 4 == 2));
         check($sformatf("rr c%0d host_rvalid", c), 32'(host_rvalid), 32'(c % 4 == 0 && c > 0));
         if (c % 4 == 2) check($sformatf("rr c%0d cpu_rdata", c), cpu_rdata, R);
         if (c % 4 == 0 && c > 0) check($sformatf("rr c%0d host_rdata", c), host_rdata, D);
      end
      cpu_req = 0; host_req = 0;
      tick(); tick();

      // CPU holds req across ack: two reads, rvalid pulses two cycles apart.
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
      n_rv = 0; rv_idx[0] = -1; rv_idx[1] = -1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (cpu_rvalid) begin
            if (n_rv < 2) rv_idx[n_rv] = c;
            n_rv++;
         end
         if (c == 3) cpu_req = 0;
      end
      check("held rvalid count", n_rv, 2);
      check("held first rvalid cycle", rv_idx[0], 2);
      check("held rvalid spacing", rv_idx[1] - rv_idx[0], 2);
      check("held cpu_rdata", cpu_rdata, R);

      // Reset during a host write's ACC cycle: no commit, everything cleared next cycle.
      tick();
      host_req = 1; host_we = 1; host_addr = 32'h40; host_wdata = 32'h22222222;
      tick();
      reset = 1'b1;
      @(negedge clk);
      check("rst host_ack in ACC", 32'(host_ack), 32'd1);
      check("rst mem_we gated", 32'(mem_we), 32'd0);
      host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("rst mem word 0x40", mem[16], 32'h11111111);
      check("rst cpu_ack", 32'(cpu_ack), 32'd0);
      check("rst host_ack", 32'(host_ack), 32'd0);
      check("rst cpu_rvalid", 32'(cpu_rvalid), 32'd0);
      check("rst host_rvalid", 32'(host_rvalid), 32'd0);
      check("rst cpu_rdata", cpu_rdata, 32'd0);
      check("rst host_rdata", host_rdata, 32'd0);
      check("rst mem_we", 32'(mem_we), 32'd0);
      check("rst mem_addr", mem_addr, 32'd0);
      check("rst mem_wdata", mem_wdata, 32'd0);

`ifdef MEM_ARB_PERF_EN
      // Three contended grants (CPU, HOST, CPU) then two CPU-only grants.
      check("perf cpu after reset", perf_cpu_grants, 32'd0);
      check("perf conflicts after reset", perf_conflicts, 32'd0);
      tick();
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
      host_req = 1; host_we = 0; host_addr = 32'h20;
      repeat (5) tick();
      host_req = 0;
      repeat (4) tick();
      cpu_req = 0;
      repeat (2) tick();
      check("perf_cpu_grants", perf_cpu_grants, 32'd4);
      check("perf_host_grants", perf_host_grants, 32'd1);
      check("perf_conflicts", perf_conflicts, 32'd3);
      perf_clr = 1'b1;
      tick();
      perf_clr = 1'b0;
      @(negedge clk);
      check("perf_cpu_grants clr", perf_cpu_grants, 32'd0);
      check("perf_host_grants clr", perf_host_grants, 32'd0);
      check("perf_conflicts clr", perf_conflicts, 32'd0);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single unified instruction/data memory between the multicycle RV32I core and a host loader/debug port. It serializes accesses, latches each winner's address and data, and drives the memory for one access cycle. It returns registered read data with a one-cycle valid pulse. It sits between `CPU_rv32i`'s memory interface (and the host port) and the word-addressed memory array.

## Interface
- `ADDR_W`, 32, address width of both requesters and the memory port.
- `DATA_W`, 32, data width.
- `clk  in  1  sole clock, all state on posedge`
- `reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high`
- `cpu_req  in  1  CPU access request; held with addr/we/wdata stable until cpu_ack`
- `cpu_we  in  1  1 = write, 0 = read`
- `cpu_addr  in  ADDR_W  byte address (word-aligned)`
- `cpu_wdata  in  DATA_W  write data`
- `cpu_ack  out  1  request accepted (high during its access cycle)`
- `cpu_rvalid  out  1  one-cycle pulse, cpu_rdata valid`
- `cpu_rdata  out  DATA_W  registered read data`
- `host_req`, `host_we`, `host_addr`, `host_wdata`, `host_ack`, `host_rvalid`, `host_rdata`: same directions, widths and meaning for the host port
- `mem_addr  out  ADDR_W  memory address`
- `mem_wdata  out  DATA_W  memory write data`
- `mem_we  out  1  memory write enable, committed at posedge`
- `mem_rdata  in  DATA_W  combinational memory read data`

## Operation
- FSM states: IDLE, ACC. Reset state IDLE.
- IDLE: at each posedge, sample `cpu_req`/`host_req`. If any are high, latch the winner's id, we, addr and wdata, and go to ACC. Otherwise stay in IDLE.
- Arbitration: round-robin on `last_grant`. A single requester always wins. If both request, the port not granted last wins. `last_grant` resets to HOST, so the CPU wins the first tie.
- ACC: `mem_addr`/`mem_wdata` are driven from the latched regs, and `mem_we` = latched we. The winner's `*_ack` = 1. `mem_rdata` is captured into the winner's `*_rdata` at the closing posedge if it is a read. Then return to IDLE and update `last_grant`.
- `*_rvalid` is registered. It is high for exactly the one cycle after a read's ACC cycle. Writes produce no rvalid.
- `*_rdata` holds its value until the next read on that port.
- Requester rule: after seeing `*_ack`, the requester must deassert `req` or present a new request before the next posedge. `req` held high is treated as a new request.
- In IDLE, `mem_addr`/`mem_wdata` = 0 and `mem_we` = 0.
- Address/data are passed through unmodified. Alignment is the requester's responsibility.

## Timing
- Read latency: `req` sampled at edge E0 → ack during cycle E0–E1 → rvalid/rdata during cycle E1–E2.
- Maximum throughput is one access per 2 cycles, shared between both ports. Under continuous contention each port gets one access per 4 cycles, so starvation cannot occur.
- A write commits at the posedge ending ACC.
- Reset values: all `*_ack`, `*_rvalid`, `mem_we` = 0. `*_rdata`, `mem_addr`, `mem_wdata` = 0. `last_grant` = HOST.
- `mem_we` is gated by `~reset`. If reset is asserted during ACC, no write commits and no rvalid follows. The next cycle is IDLE.
- A `req` raised during ACC is not seen until the following IDLE edge.
- Simultaneous `req` rise on both ports in the same cycle is resolved by round-robin.

## Configuration
- `MEM_ARB_PERF_EN` defined: adds outputs `perf_cpu_grants`, `perf_host_grants` and `perf_conflicts` (32-bit each, saturating at 0xFFFFFFFF, reset to 0).
  - `perf_cpu_grants` / `perf_host_grants` increment on each grant to that port.
  - `perf_conflicts` increments on each IDLE edge where both `req` are high.
  - Adds input `perf_clr`, which synchronously zeroes all three counters. `perf_clr` takes precedence over increment.
- `MEM_ARB_PERF_EN` undefined: these ports and counters do not exist, and arbitration behaviour is identical.

## Test plan
- CPU reads address 0x10 with memory word 4 = 0x00A00093: ack one cycle after req sampled, cpu_rvalid 2 cycles after, cpu_rdata = 0x00A00093, host outputs idle.
- Host writes 0xDEADBEEF to 0x20, then the CPU reads 0x20: `mem_we` is high for exactly one cycle, and `cpu_rdata` = 0xDEADBEEF.
- Both ports request reads continuously from reset:
  - grant order is CPU, HOST, CPU, HOST…
  - each port's ack is spaced 4 cycles apart
  - no missed or duplicate rvalid
- Assert reset during a host write's ACC cycle to 0x40, which holds 0x11111111:
  - `mem_we` is 0 at that edge
  - word 0x40 is still 0x11111111
  - all outputs are 0 the next cycle
- CPU holds `req` high across ack with we=0: a second access starts at the next IDLE edge, and the bench sees 2 rvalid pulses spaced 2 cycles apart.
- With `MEM_ARB_PERF_EN`: 3 contended cycles followed by 2 CPU-only requests give `perf_cpu_grants` = 4, `perf_host_grants` = 1, `perf_conflicts` = 3. `perf_clr` zeroes all three counters.
